// File: rtl/ternary_program_loader_pkg.sv
// Shared definitions for the ternary program loader: trit codes, sizes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ternary_program_loader_pkg;

  localparam int TPL_WORD_TRITS = 9;
  localparam int TPL_MAX_WORDS  = 243;
  localparam int TPL_COUNT_W    = 10;

  // Two-bit trit codes; 2'b11 never appears in a legal word.
  localparam logic [1:0] TRIT_ZERO  = 2'b00;
  localparam logic [1:0] TRIT_PLUS  = 2'b01;
  localparam logic [1:0] TRIT_MINUS = 2'b10;
  localparam logic [1:0] TRIT_BAD   = 2'b11;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_DRAIN = 2'd2
  } ld_state_e;

endpackage

// File: rtl/ternary_program_loader_if.sv
// Valid/ready word stream from the program source into the loader.
// Latency: n/a (wires only).
// Backpressure: the consumer drives in_ready; a word moves when in_valid & in_ready.
interface ternary_program_loader_if
  import ternary_program_loader_pkg::*;
#(
  parameter int WORD_TRITS = TPL_WORD_TRITS
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic [2*WORD_TRITS-1:0] in_data;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/ternary_program_loader_incrementer.sv
// Balanced-ternary +1 on a word of WORD_TRITS trits; all-'+' wraps to all-'-'.
// Latency: combinational.
// Backpressure: none.
module ternary_incrementer
  import ternary_program_loader_pkg::*;
#(
  parameter int WORD_TRITS = TPL_WORD_TRITS
)(
  input  logic [2*WORD_TRITS-1:0] i_word,
  output logic [2*WORD_TRITS-1:0] o_word
);

  logic w_carry;

  // Ripple the +1 from trit 0 upward; only a '+' trit passes the carry on.
  always_comb begin
    o_word  = i_word;
    w_carry = 1'b1;
    for (int t = 0; t < WORD_TRITS; t++) begin
      if (w_carry) begin
        case (i_word[2*t +: 2])
          TRIT_ZERO: begin
            o_word[2*t +: 2] = TRIT_PLUS;
            w_carry          = 1'b0;
          end
          TRIT_MINUS: begin
            o_word[2*t +: 2] = TRIT_ZERO;
            w_carry          = 1'b0;
          end
          TRIT_PLUS: begin
            o_word[2*t +: 2] = TRIT_MINUS;
          end
          default: begin
            // Invalid code: leave it alone; the loader never writes such words.
            w_carry = 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ternary_program_loader.sv
// Streams a program image into ternary instruction memory, generating addresses and strobes.
// Latency: accepted word appears on the memory write port exactly 1 cycle later; done 1 cycle after last write.
// Backpressure: in_ready high only while loading; no stalls inside an image, one write per accept.
module ternary_program_loader
  import ternary_program_loader_pkg::*;
#(
  parameter int                      WORD_TRITS = TPL_WORD_TRITS,
  parameter int                      MAX_WORDS  = TPL_MAX_WORDS,
  parameter logic [2*WORD_TRITS-1:0] BASE_ADDR  = '0
)(
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_start,
  ternary_program_loader_if.slave      if_src,
  output logic                         o_mem_write,
  output logic [2*WORD_TRITS-1:0]      o_mem_addr,
  output logic [2*WORD_TRITS-1:0]      o_mem_write_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_error,
  output logic [TPL_COUNT_W-1:0]       o_word_count
);

  localparam int W  = 2 * WORD_TRITS;
  localparam int CW = TPL_COUNT_W;

  ld_state_e         r_state;
  ld_state_e         w_state_nxt;
  logic              r_armed;
  logic [W-1:0]      r_addr;
  logic [W-1:0]      w_addr_inc;
  logic              r_mem_write;
  logic [W-1:0]      r_mem_addr;
  logic [W-1:0]      r_mem_data;
  logic              r_done;
  logic              r_error;
  logic [CW-1:0]     r_count;

  logic              w_in_ready;
  logic              w_start_load;
  logic              w_write_en;
  logic              w_err_set;
  logic              w_done_set;
  logic              w_bad_trit;
  logic              w_full;

  ternary_incrementer #(.WORD_TRITS(WORD_TRITS)) u_incr (
    .i_word (r_addr),
    .o_word (w_addr_inc)
  );

  // Flag any trit carrying the reserved code in the offered word.
  always_comb begin
    w_bad_trit = 1'b0;
    for (int t = 0; t < WORD_TRITS; t++) begin
      if (if_src.in_data[2*t +: 2] == TRIT_BAD) begin
        w_bad_trit = 1'b1;
      end
    end
  end

  assign w_full = (r_count == CW'(MAX_WORDS));

  // Next state and per-cycle actions of the load sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_start_load = 1'b0;
    w_write_en   = 1'b0;
    w_err_set    = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      LD_IDLE: begin
        // r_armed masks a start that arrives on the first edge after reset release.
        if (i_start && r_armed) begin
          w_start_load = 1'b1;
          w_state_nxt  = LD_LOAD;
        end
      end
      LD_LOAD: begin
        w_in_ready = 1'b1;
        if (if_src.in_valid) begin
          if (w_bad_trit || w_full) begin
            w_err_set   = 1'b1;
            w_state_nxt = LD_IDLE;
          end else begin
            w_write_en = 1'b1;
            if (if_src.in_last) begin
              w_state_nxt = LD_DRAIN;
            end
          end
        end
      end
      LD_DRAIN: begin
        w_done_set  = 1'b1;
        w_state_nxt = LD_IDLE;
      end
      default: begin
        w_state_nxt = LD_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= LD_IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
    end
  end

  // Address generator, word counter and registered memory/status outputs.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_addr      <= BASE_ADDR;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_count     <= '0;
    end else begin
      r_mem_write <= w_write_en;
      r_done      <= w_done_set;
      if (w_start_load) begin
        r_addr  <= BASE_ADDR;
        r_count <= '0;
        r_error <= 1'b0;
      end
      if (w_err_set) begin
        r_error <= 1'b1;
      end
      if (w_write_en) begin
        r_mem_addr <= r_addr;
        r_mem_data <= if_src.in_data;
        r_addr     <= w_addr_inc;
        r_count    <= r_count + CW'(1);
      end
    end
  end

  assign if_src.in_ready  = w_in_ready;
  assign o_mem_write      = r_mem_write;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_write_data = r_mem_data;
  assign o_busy           = (r_state != LD_IDLE);
  assign o_done           = r_done;
  assign o_error          = r_error;
  assign o_word_count     = r_count;

endmodule

// File: tb/tb_ternary_program_loader.sv
// Bench for ternary_program_loader: three instances (base 0, 1, 3) share one stimulus stream.
// Latency: a spec-level model predicts every output each cycle.
// Backpressure: source words are offered regardless of in_ready; the model decides acceptance.
module tb_ternary_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        vld;
  logic        lst;
  logic [17:0] dat;

  logic        mw  [3];
  logic [17:0] ma  [3];
  logic [17:0] md  [3];
  logic        rdy [3];
  logic        bsy [3];
  logic        dn  [3];
  logic        er  [3];
  logic [9:0]  wc  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [17:0] BASE = (g == 0) ? 18'h0 : ((g == 1) ? 18'h1 : 18'h4);
    ternary_program_loader_if #(.WORD_TRITS(9)) src_if ();
    assign src_if.in_valid = vld;
    assign src_if.in_data  = dat;
    assign src_if.in_last  = lst;
    assign rdy[g]          = src_if.in_ready;
    ternary_program_loader #(.WORD_TRITS(9), .MAX_WORDS(243), .BASE_ADDR(BASE)) u_dut (
      .i_clock          (clk),
      .i_reset          (rst_n),
      .i_start          (start),
      .if_src           (src_if.slave),
      .o_mem_write      (mw[g]),
      .o_mem_addr       (ma[g]),
      .o_mem_write_data (md[g]),
      .o_busy           (bsy[g]),
      .o_done           (dn[g]),
      .o_error          (er[g]),
      .o_word_count     (wc[g])
    );
  end

  int errors = 0;
  int checks = 0;

  // Reference model: what the outputs must show after the most recent edge.
  int          base_int [3] = '{0, 1, 3};
  int          m_phase;   // 0 idle, 1 loading, 2 final write in flight
  bit          m_armed;
  bit          m_wr;
  bit          m_done;
  bit          m_err;
  int          m_cnt;
  int          m_widx;
  logic [17:0] m_wdata;

  int          log_a0[$];
  logic [17:0] log_d0[$];
  logic [17:0] log_r1[$];
  logic [17:0] log_r2[$];
  int          done_cnt = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Integer -> balanced-ternary word, modulo 3^9 into the symmetric range.
  function automatic logic [17:0] enc(input int v);
    logic [17:0] w;
    int x;
    int r;
    x = v % 19683;
    if (x > 9841) x -= 19683;
    if (x < -9841) x += 19683;
    w = '0;
    for (int t = 0; t < 9; t++) begin
      r = ((x % 3) + 3) % 3;
      if (r == 0) begin w[2*t +: 2] = 2'b00; x = x / 3; end
      else if (r == 1) begin w[2*t +: 2] = 2'b01; x = (x - 1) / 3; end
      else begin w[2*t +: 2] = 2'b10; x = (x + 1) / 3; end
    end
    return w;
  endfunction

  function automatic int dec(input logic [17:0] w);
    int s;
    int p;
    s = 0;
    p = 1;
    for (int t = 0; t < 9; t++) begin
      if (w[2*t +: 2] == 2'b01) s += p;
      else if (w[2*t +: 2] == 2'b10) s -= p;
      p *= 3;
    end
    return s;
  endfunction

  function automatic bit has_bad(input logic [17:0] w);
    bit b;
    b = 1'b0;
    for (int t = 0; t < 9; t++) if (w[2*t +: 2] == 2'b11) b = 1'b1;
    return b;
  endfunction

  function automatic logic [17:0] rand_word(input bit bad);
    logic [17:0] w;
    int k;
    for (int t = 0; t < 9; t++) begin
      k = $urandom_range(0, 2);
      w[2*t +: 2] = (k == 0) ? 2'b00 : ((k == 1) ? 2'b01 : 2'b10);
    end
    if (bad) begin
      k = $urandom_range(0, 8);
      w[2*k +: 2] = 2'b11;
    end
    return w;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_phase = 0; m_wr = 0; m_done = 0; m_err = 0; m_cnt = 0; m_armed = 0;
    end else begin
      m_wr   = 0;
      m_done = 0;
      if (m_phase == 0) begin
        if (start && m_armed) begin m_phase = 1; m_cnt = 0; m_err = 0; end
      end else if (m_phase == 1) begin
        if (vld) begin
          if (has_bad(dat) || m_cnt == 243) begin
            m_err = 1; m_phase = 0;
          end else begin
            m_wr = 1; m_widx = m_cnt; m_wdata = dat; m_cnt++;
            if (lst) m_phase = 2;
          end
        end
      end else begin
        m_done = 1; m_phase = 0;
      end
      m_armed = 1;
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 3; d++) begin
      chk("mem_write", d, mw[d], m_wr);
      if (m_wr) begin
        chk("mem_addr", d, ma[d], enc(base_int[d] + m_widx));
        chk("mem_data", d, md[d], m_wdata);
      end
      chk("done", d, dn[d], m_done);
      chk("error", d, er[d], m_err);
      chk("busy", d, bsy[d], m_phase != 0);
      chk("in_ready", d, rdy[d], m_phase == 1);
      chk("word_count", d, wc[d], m_cnt);
    end
    if (mw[0]) begin log_a0.push_back(dec(ma[0])); log_d0.push_back(md[0]); end
    if (mw[1]) log_r1.push_back(ma[1]);
    if (mw[2]) log_r2.push_back(ma[2]);
    if (dn[0]) done_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [17:0] w, input bit last);
    vld = 1'b1; dat = w; lst = last;
    tick();
    vld = 1'b0; lst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    log_a0.delete(); log_d0.delete(); log_r1.delete(); log_r2.delete();
  endtask

  initial begin
    int dsave;
    int len;
    rst_n = 1'b0; start = 1'b0; vld = 1'b0; lst = 1'b0; dat = '0;

    fork
      forever begin @(posedge clk); model_step(); end
      forever begin @(negedge clk); compare(); end
    join_none

    // Reset held with start/in_valid toggling.
    for (int i = 0; i < 3; i++) begin
      start = ~start; vld = ~vld; dat = rand_word(0);
      tick();
    end
    chk("rst_mem_write", 0, mw[0], 0);
    chk("rst_mem_addr", 0, ma[0], 0);
    chk("rst_mem_data", 0, md[0], 0);
    chk("rst_busy", 0, bsy[0], 0);
    chk("rst_done", 0, dn[0], 0);
    chk("rst_error", 0, er[0], 0);
    chk("rst_word_count", 0, wc[0], 0);
    chk("rst_in_ready", 0, rdy[0], 0);

    // Start coincident with reset release is ignored.
    rst_n = 1'b1; start = 1'b1; vld = 1'b0;
    tick();
    start = 1'b0;
    chk("start_at_release", 0, bsy[0], 0);
    idle(1);

    // Three back-to-back words, last on the third.
    clear_logs();
    dsave = done_cnt;
    pulse_start();
    send(18'h00001, 0);
    send(18'h2AAAA, 0);
    send(18'h15555, 1);
    chk("t2_last_write", 0, mw[0], 1);
    chk("t2_last_addr", 0, ma[0], 18'h6);
    chk("t2_done_early", 0, dn[0], 0);
    chk("t2_drain_busy", 0, bsy[0], 1);
    tick();
    chk("t2_done", 0, dn[0], 1);
    chk("t2_busy_done", 0, bsy[0], 0);
    chk("t2_word_count", 0, wc[0], 3);
    tick();
    chk("t2_done_once", 0, dn[0], 0);
    idle(1);
    chk("t2_nwrites", 0, log_a0.size(), 3);
    chk("t2_addr0", 0, log_a0[0], 0);
    chk("t2_addr1", 0, log_a0[1], 1);
    chk("t2_addr2", 0, log_a0[2], 2);
    chk("t2_data1", 0, log_d0[1], 18'h2AAAA);
    chk("t2_done_cnt", 0, done_cnt - dsave, 1);
    // Ternary carry behaviour on the other bases.
    chk("t3_b1_addr0", 1, log_r1[0], 18'h1);
    chk("t3_b1_addr1", 1, log_r1[1], 18'h6);
    chk("t3_b3_addr0", 2, log_r2[0], 18'h4);
    chk("t3_b3_addr1", 2, log_r2[1], 18'h5);

    // Valid gaps inside an image.
    clear_logs();
    pulse_start();
    send(rand_word(0), 0);
    idle(2);
    send(rand_word(0), 1);
    idle(3);
    chk("t4_nwrites", 0, log_a0.size(), 2);
    chk("t4_addr0", 0, log_a0[0], 0);
    chk("t4_addr1", 0, log_a0[1], 1);

    // Invalid trit in the second word.
    clear_logs();
    dsave = done_cnt;
    pulse_start();
    send(18'h00005, 0);
    send(18'h000C0, 0);
    send(rand_word(0), 0);
    send(rand_word(0), 1);
    idle(2);
    chk("t5_nwrites", 0, log_a0.size(), 1);
    chk("t5_error", 0, er[0], 1);
    chk("t5_no_done", 0, done_cnt - dsave, 0);
    chk("t5_idle", 0, bsy[0], 0);
    pulse_start();
    chk("t5_error_clr", 0, er[0], 0);
    send(rand_word(0), 1);
    idle(2);

    // Reset in the middle of an image.
    pulse_start();
    send(rand_word(0), 0);
    send(rand_word(0), 0);
    rst_n = 1'b0; vld = 1'b1; dat = rand_word(0);
    tick();
    vld = 1'b0;
    chk("t6_mem_write", 0, mw[0], 0);
    chk("t6_word_count", 0, wc[0], 0);
    chk("t6_busy", 0, bsy[0], 0);
    tick();
    rst_n = 1'b1;
    idle(2);
    clear_logs();
    pulse_start();
    send(rand_word(0), 0);
    send(rand_word(0), 0);
    send(rand_word(0), 1);
    idle(2);
    chk("t6_nwrites", 0, log_a0.size(), 3);
    chk("t6_addr0", 0, log_a0[0], 0);
    chk("t6_addr2", 0, log_a0[2], 2);

    // Exactly MAX_WORDS words is legal.
    dsave = done_cnt;
    pulse_start();
    for (int i = 0; i < 243; i++) send(rand_word(0), i == 242);
    idle(2);
    chk("max_done", 0, done_cnt - dsave, 1);
    chk("max_error", 0, er[0], 0);
    chk("max_word_count", 0, wc[0], 243);

    // One word past MAX_WORDS without last overflows.
    dsave = done_cnt;
    pulse_start();
    for (int i = 0; i < 244; i++) send(rand_word(0), 0);
    idle(1);
    chk("ovf_error", 0, er[0], 1);
    chk("ovf_word_count", 0, wc[0], 243);
    chk("ovf_busy", 0, bsy[0], 0);
    chk("ovf_no_done", 0, done_cnt - dsave, 0);

    // Randomised images: gaps, stray starts, bad trits, resets.
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 2));
      pulse_start();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        start = ($urandom_range(0, 5) == 0);
        send(rand_word($urandom_range(0, 11) == 0), i == len - 1);
        start = 1'b0;
        if ($urandom_range(0, 29) == 0) begin
          rst_n = 1'b0;
          idle(2);
          rst_n = 1'b1;
          start = ($urandom_range(0, 1) == 0);
          tick();
          start = 1'b0;
        end
      end
      idle(2);
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
